// File: rtl/ula_sequenciador.sv
// ----------------------------------------------------------------------------
// ula_sequenciador
//
// Sequences one instruction at a time through an external combinational ALU.
// Each accepted instruction walks IDLE -> LEITURA -> EXECUTA -> ESCRITA:
// operands are read from an 8 x bits_palavra register file, presented to the
// ALU, the ALU result and flags are captured, and then written back. One
// instruction is accepted every 4 cycles at most.
//
// Optional feature (macro ULA_ILEGAL_EN):
//   When defined, codes 00010, 00111 and 01010..01111 are rejected. The FSM
//   goes IDLE -> LEITURA -> IDLE and pulses done and erro together. Nothing
//   else changes. When undefined, every code executes and erro is tied to 0.
//
// Ports:
//   clock        single clock, rising-edge
//   reset        asynchronous, active-high
//   instr_valid  instruction offered this cycle
//   instr_ready  block accepts an instruction this cycle (IDLE only)
//   instrucao    [15:11] ALU code, [10:8] rd, [7:5] ra, [4:2] rb, [1:0] unused
//   controle     ALU control code (registered)
//   operandoA/B  ALU operands (registered)
//   resultadoOp  ALU result
//   Z, C, S, O   ALU flags
//   flags        registered {Z, C, S, O} of the last completed instruction
//   done         one-cycle pulse on writeback or on rejection
//   erro         one-cycle pulse, coincident with done, on rejection
//   dbg_addr     register file debug read address
//   dbg_data     combinational read of r[dbg_addr]
// ----------------------------------------------------------------------------
module ula_sequenciador #(
    parameter int unsigned bits_palavra = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [15:0]             instrucao,
    output logic [4:0]              controle,
    output logic [bits_palavra-1:0] operandoA,
    output logic [bits_palavra-1:0] operandoB,
    input  logic [bits_palavra-1:0] resultadoOp,
    input  logic                    Z,
    input  logic                    C,
    input  logic                    S,
    input  logic                    O,
    output logic [3:0]              flags,
    output logic                    done,
    output logic                    erro,
    input  logic [2:0]              dbg_addr,
    output logic [bits_palavra-1:0] dbg_data
);

    typedef enum logic [1:0] {
        StIdle,
        StLeitura,
        StExecuta,
        StEscrita
    } estado_e;

    estado_e state_q, state_d;

    // Latched instruction fields; bits [1:0] carry no meaning.
    logic [15:2] instr_q;
    logic [4:0]  codigo;
    logic [2:0]  rd;
    logic [2:0]  ra;
    logic [2:0]  rb;

    logic unused_instr_bits;

    // Register file and captured ALU outputs.
    logic [bits_palavra-1:0] regs_q [8];
    logic [bits_palavra-1:0] res_q;
    logic [3:0]              flg_q;

    // FSM-decoded strobes.
    logic aceita;
    logic carrega_op;
    logic captura;
    logic escreve;
    logic rejeita;
    logic ilegal;

    assign codigo = instr_q[15:11];
    assign rd     = instr_q[10:8];
    assign ra     = instr_q[7:5];
    assign rb     = instr_q[4:2];

    assign unused_instr_bits = ^instrucao[1:0];

    // ------------------------------------------------------------------------
    // Illegal-code decode
    // ------------------------------------------------------------------------
`ifdef ULA_ILEGAL_EN
    always_comb begin
        ilegal = 1'b0;
        case (codigo)
            5'b00010, 5'b00111,
            5'b01010, 5'b01011, 5'b01100,
            5'b01101, 5'b01110, 5'b01111: ilegal = 1'b1;
            default:                      ilegal = 1'b0;
        endcase
    end
`else
    assign ilegal = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (aceita) state_d = StLeitura;
            StLeitura: state_d = ilegal ? StIdle : StExecuta;
            StExecuta: state_d = StEscrita;
            StEscrita: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs / strobes
    // ------------------------------------------------------------------------
    always_comb begin
        instr_ready = 1'b0;
        carrega_op  = 1'b0;
        captura     = 1'b0;
        escreve     = 1'b0;
        rejeita     = 1'b0;
        unique case (state_q)
            StIdle:    instr_ready = 1'b1;
            StLeitura: begin
                carrega_op = ~ilegal;
                rejeita    = ilegal;
            end
            StExecuta: captura = 1'b1;
            StEscrita: escreve = 1'b1;
            default:   instr_ready = 1'b0;
        endcase
    end

    // instr_valid outside IDLE is dropped, never queued.
    assign aceita = instr_valid & instr_ready;

    // ------------------------------------------------------------------------
    // Instruction latch
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
        end else if (aceita) begin
            instr_q <= instrucao[15:2];
        end
    end

    // ------------------------------------------------------------------------
    // ALU interface: operands and code only change in LEITURA, so they hold
    // their last values everywhere else, including after a rejection.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            controle  <= '0;
            operandoA <= '0;
            operandoB <= '0;
        end else if (carrega_op) begin
            controle  <= codigo;
            operandoA <= regs_q[ra];
            operandoB <= regs_q[rb];
        end
    end

    // Capture ALU result and flags while the operands are stable (EXECUTA).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res_q <= '0;
            flg_q <= '0;
        end else if (captura) begin
            res_q <= resultadoOp;
            flg_q <= {Z, C, S, O};
        end
    end

    // ------------------------------------------------------------------------
    // Register file. r0 is never written, so it always reads as zero.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (escreve && (rd != 3'd0)) begin
            regs_q[rd] <= res_q;
        end
    end

    assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];

    // ------------------------------------------------------------------------
    // Flags and completion pulses
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags <= '0;
        end else if (escreve) begin
            flags <= flg_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= escreve | rejeita;
        end
    end

`ifdef ULA_ILEGAL_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            erro <= 1'b0;
        end else begin
            erro <= rejeita;
        end
    end
`else
    assign erro = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Sanity properties
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    a_erro_implica_done: assert property (@(posedge clock) disable iff (reset)
        erro |-> done);
    a_escrita_gera_done: assert property (@(posedge clock) disable iff (reset)
        (state_q == StEscrita) |=> done);
`endif

endmodule

// File: tb/tb_ula_sequenciador.sv
// ----------------------------------------------------------------------------
// tb_ula_sequenciador
//
// Self-checking bench for ula_sequenciador. A behavioural ALU drives the
// DUT's ALU inputs; a register-file/flag model tracks what every instruction
// must leave behind. Directed cases come first, followed by random ones.
// ----------------------------------------------------------------------------
module tb_ula_sequenciador;

    localparam int W = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instrucao;
    logic [4:0]    controle;
    logic [W-1:0]  operandoA;
    logic [W-1:0]  operandoB;
    logic [W-1:0]  resultadoOp;
    logic          Z, C, S, O;
    logic [3:0]    flags;
    logic          done;
    logic          erro;
    logic [2:0]    dbg_addr;
    logic [W-1:0]  dbg_data;

    always #5 clock = ~clock;

    ula_sequenciador #(
        .bits_palavra(W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instrucao   (instrucao),
        .controle    (controle),
        .operandoA   (operandoA),
        .operandoB   (operandoB),
        .resultadoOp (resultadoOp),
        .Z           (Z),
        .C           (C),
        .S           (S),
        .O           (O),
        .flags       (flags),
        .done        (done),
        .erro        (erro),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // ------------------------------------------------------------------------
    // Behavioural ALU: returns {Z, C, S, O, result}. A forced value lets the
    // bench load arbitrary constants into the register file.
    // ------------------------------------------------------------------------
    function automatic logic [19:0] alu_ref(input logic [4:0] code, input logic [15:0] a,
                                            input logic [15:0] b, input logic forcar,
                                            input logic [15:0] valor);
        logic [16:0] soma;
        logic [15:0] r;
        logic        c;
        logic        o;
        c = 1'b0;
        o = 1'b0;
        if (forcar) begin
            r = valor;
        end else begin
            case (code)
                5'd0: begin
                    soma = {1'b0, a} + {1'b0, b};
                    r    = soma[15:0];
                    c    = soma[16];
                    o    = (a[15] == b[15]) && (r[15] != a[15]);
                end
                5'd1: begin
                    r = a - b;
                    c = (a < b);
                end
                5'd2:    r = a & b;
                5'd3:    r = a | b;
                5'd4:    r = a ^ b;
                5'd5:    r = ~a;
                5'd6: begin
                    r = a << 1;
                    c = a[15];
                end
                5'd7: begin
                    r = a >> 1;
                    c = a[0];
                end
                5'd31:   r = 16'hFFFF;
                default: r = a + b + {11'd0, code};
            endcase
        end
        return {(r == 16'd0), c, r[15], o, r};
    endfunction

    logic        alu_forcar;
    logic [15:0] alu_valor;
    logic [3:0]  fl_alu;

    assign {fl_alu, resultadoOp} = alu_ref(controle, operandoA, operandoB, alu_forcar,
                                           alu_valor);
    assign {Z, C, S, O} = fl_alu;

    // ------------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------------
    logic [15:0] mdl_r [8];
    logic [3:0]  mdl_flags;
    logic [4:0]  mdl_ctrl;
    logic [15:0] mdl_a;
    logic [15:0] mdl_b;

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic ilegal_ref(input logic [4:0] code);
`ifdef ULA_ILEGAL_EN
        return (code == 5'd2) || (code == 5'd7) || (code >= 5'd10 && code <= 5'd15);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl_r[i] = '0;
        mdl_flags = '0;
        mdl_ctrl  = '0;
        mdl_a     = '0;
        mdl_b     = '0;
    endtask

    // Applies one legal instruction to the model.
    task automatic model_exec(input logic [4:0] code, input logic [2:0] rd,
                              input logic [2:0] ra, input logic [2:0] rb,
                              input logic forcar, input logic [15:0] valor);
        logic [19:0] r;
        r        = alu_ref(code, mdl_r[ra], mdl_r[rb], forcar, valor);
        mdl_ctrl = code;
        mdl_a    = mdl_r[ra];
        mdl_b    = mdl_r[rb];
        if (rd != 3'd0) mdl_r[rd] = r[15:0];
        mdl_flags = r[19:16];
    endtask

    // Sweeps the register file and ALU-facing outputs against the model.
    task automatic check_state();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check_eq("reg", dbg_data, mdl_r[i]);
        end
        check_eq("flags", flags, mdl_flags);
        check_eq("controle_hold", controle, mdl_ctrl);
        check_eq("opA_hold", operandoA, mdl_a);
        check_eq("opB_hold", operandoB, mdl_b);
    endtask

    // Issues one instruction and follows it to completion.
    task automatic executar(input logic [4:0] code, input logic [2:0] rd, input logic [2:0] ra,
                            input logic [2:0] rb, input logic forcar, input logic [15:0] valor);
        logic        rej;
        logic [1:0]  lixo;
        int          k;
        rej  = ilegal_ref(code);
        lixo = 2'($urandom);
        @(negedge clock);
        alu_forcar = forcar;
        alu_valor  = valor;
        dbg_addr   = rd;
        check_eq("ready_idle", instr_ready, 1);
        instrucao   = {code, rd, ra, rb, lixo};
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        instrucao   = 16'($urandom);
        k = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (done) begin
                k = i;
                break;
            end
            check_eq("ready_busy", instr_ready, 0);
            if (i == 2 && !rej) begin
                check_eq("controle_exec", controle, code);
                check_eq("opA_exec", operandoA, mdl_r[ra]);
                check_eq("opB_exec", operandoB, mdl_r[rb]);
            end
        end
        if (k == 0) k = 99;
        check_eq("latencia", k, rej ? 2 : 4);
        check_eq("erro", erro, rej);
        if (!rej) model_exec(code, rd, ra, rb, forcar, valor);
        check_eq("dbg_rd", dbg_data, mdl_r[rd]);
        check_eq("flags_done", flags, mdl_flags);
        @(negedge clock);
        check_eq("done_pulse", done, 0);
        check_eq("erro_pulse", erro, 0);
    endtask

    initial begin
        int acc;
        int dones;
        logic [19:0] r;

        reset       = 1'b1;
        instr_valid = 1'b0;
        instrucao   = '0;
        dbg_addr    = '0;
        alu_forcar  = 1'b0;
        alu_valor   = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clock);
        check_eq("rst_done", done, 0);
        reset = 1'b0;
        #1;
        check_eq("rst_ready", instr_ready, 1);
        check_eq("rst_erro", erro, 0);
        check_state();

        // Code 11111 into r1: ALU gives 0xFFFF, flags 0010
        executar(5'b11111, 3'd1, 3'd0, 3'd0, 1'b0, 16'h0);
        dbg_addr = 3'd1;
        #1;
        check_eq("r029_r1", dbg_data, 16'hFFFF);
        check_eq("r029_flags", flags, 4'b0010);

        // r1 = 5, r2 = 3, then r3 = r1 + r2
        executar(5'd3, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005);
        executar(5'd3, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0003);
        executar(5'd0, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0);
        dbg_addr = 3'd3;
        #1;
        check_eq("r030_r3", dbg_data, 16'h0008);
        check_state();

        // Write to r0 is discarded, done still pulses
        executar(5'd0, 3'd0, 3'd1, 3'd2, 1'b1, 16'h1234);
        check_state();

        // Source equals destination (operands read before writeback)
        executar(5'd0, 3'd1, 3'd1, 3'd1, 1'b0, 16'h0);

        // instr_valid held high for 8 cycles: accepted at cycles 0 and 4 only
        acc   = 0;
        dones = 0;
        @(negedge clock);
        alu_forcar  = 1'b0;
        instrucao   = {5'd0, 3'd1, 3'd1, 3'd2, 2'b00};
        instr_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clock);
            check_eq("burst_ready", instr_ready, ((c % 4) == 0) ? 1 : 0);
            if (instr_ready) acc++;
            if (done) dones++;
            @(posedge clock);
        end
        #1;
        instr_valid = 1'b0;
        check_eq("burst_acc", acc, 2);
        check_eq("burst_dones", dones, 1);
        @(negedge clock);
        check_eq("burst_done2", done, 1);
        repeat (2) model_exec(5'd0, 3'd1, 3'd1, 3'd2, 1'b0, 16'h0);
        repeat (3) @(negedge clock);
        check_eq("burst_idle_done", done, 0);
        check_state();

        // Code 01010 into r4 (rejected when the illegal-code check is built in)
        executar(5'd3, 3'd4, 3'd0, 3'd0, 1'b1, 16'hABCD);
        executar(5'b01010, 3'd4, 3'd1, 3'd2, 1'b0, 16'h0);
        r = alu_ref(5'b01010, mdl_r[1], mdl_r[2], 1'b0, 16'h0);
        dbg_addr = 3'd4;
        #1;
`ifdef ULA_ILEGAL_EN
        check_eq("r034_r4", dbg_data, 16'hABCD);
`else
        check_eq("r034_r4", dbg_data, r[15:0]);
`endif
        check_state();

        // Reset asserted while in EXECUTA aborts the instruction
        @(negedge clock);
        instrucao   = {5'd0, 3'd5, 3'd1, 3'd2, 2'b00};
        instr_valid = 1'b1;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("rst_exec_done", done, 0);
        check_eq("rst_exec_ctrl", controle, 0);
        check_eq("rst_exec_opA", operandoA, 0);
        repeat (2) begin
            @(negedge clock);
            check_eq("rst_hold_done", done, 0);
        end
        reset = 1'b0;
        model_reset();
        #1;
        check_eq("rst_rel_ready", instr_ready, 1);
        dones = 0;
        repeat (5) begin
            @(negedge clock);
            if (done) dones++;
        end
        check_eq("rst_no_done", dones, 0);
        check_state();

        // Random instructions against the model
        for (int i = 0; i < 8; i++) begin
            executar(5'd3, 3'(i), 3'd0, 3'd0, 1'b1, 16'($urandom));
        end
        for (int i = 0; i < 60; i++) begin
            executar(5'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                     ($urandom_range(3, 0) == 0), 16'($urandom));
        end
        check_state();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
